// File: rtl/fpu16_pkg.sv
// Shared definitions for the FALU16 batch sequencer.
// Opcodes, FSM states and the opcode-to-select decode.
package fpu16_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    // Bit order of the result: {div, mul, sub, add}
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (op)
            OP_ADD: oh = 4'b0001;
            OP_SUB: oh = 4'b0010;
            OP_MUL: oh = 4'b0100;
            OP_DIV: oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fpu16_capture_pipe.sv
// {valid, index} delay line matching the FALU16 latency.
// With LAT=0 the issue tag is presented in the issue cycle itself.
module fpu16_capture_pipe #(
    parameter int LAT = 0,
    parameter int IW  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx
);

    generate
        if (LAT == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out_valid = in_valid;
            assign out_idx   = in_idx;
        end else begin : g_pipe
            logic [LAT-1:0] v;
            logic [IW-1:0]  ix [LAT];

            // Shift the issue tag one stage per cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= '0;
                    for (int i = 0; i < LAT; i++) ix[i] <= '0;
                end else begin
                    v[0]  <= in_valid;
                    ix[0] <= in_idx;
                    for (int i = 1; i < LAT; i++) begin
                        v[i]  <= v[i-1];
                        ix[i] <= ix[i-1];
                    end
                end
            end

            assign out_valid = v[LAT-1];
            assign out_idx   = ix[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/fpu16_batch_seq.sv
// Batch issuer / result collector for the FALU16 half-precision ALU.
// Issues one operand pair per cycle and captures results by index.
module fpu16_batch_seq
    import fpu16_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int LAT        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    input  logic                  start,
    input  logic [1:0]            opcode,
    input  logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  falu_enable,
    output logic [15:0]           falu_op1,
    output logic [15:0]           falu_op2,
    output logic                  falu_addsel,
    output logic                  falu_subsel,
    output logic                  falu_mulsel,
    output logic                  falu_divsel,
    input  logic [15:0]           falu_result,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [15:0]           rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_W = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] ONE_I = DEPTH_LOG2'(1);

    logic [15:0] op1_mem [DEPTH];
    logic [15:0] op2_mem [DEPTH];
    logic [15:0] res_mem [DEPTH];

    state_t                state;
    logic [1:0]            op_q;
    logic [3:0]            sel_q;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DEPTH_LOG2-1:0] idx_nx;
    logic [DEPTH_LOG2-1:0] last_idx;
    logic [DEPTH_LOG2:0]   cnt_sat;
    logic                  cap_valid;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic                  last_cap;
    logic                  fin_now;

    assign cnt_sat  = (count > FULL) ? FULL : count;
    assign idx_nx   = idx + ONE_I;
    assign last_cap = cap_valid && (cap_idx == last_idx);
    assign fin_now  = (state == FIN) || ((state != IDLE) && last_cap);

    assign falu_addsel = sel_q[0];
    assign falu_subsel = sel_q[1];
    assign falu_mulsel = sel_q[2];
    assign falu_divsel = sel_q[3];

    fpu16_capture_pipe #(
        .LAT (LAT),
        .IW  (DEPTH_LOG2)
    ) u_cap (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (falu_enable),
        .in_idx    (idx),
        .out_valid (cap_valid),
        .out_idx   (cap_idx)
    );

    // Operand loads are only accepted while idle so a batch sees stable data
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE)) begin
            if (wr_sel) op2_mem[wr_addr] <= wr_data;
            else        op1_mem[wr_addr] <= wr_data;
        end
    end

    // Result write at the end of the capture delay line
    always_ff @(posedge clk) begin
        if (cap_valid) res_mem[cap_idx] <= falu_result;
    end

    // Registered result read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= res_mem[rd_addr];
    end

    // Batch FSM; all FALU-facing outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            sel_q       <= '0;
            idx         <= '0;
            last_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            falu_enable <= 1'b0;
            falu_op1    <= '0;
            falu_op2    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= opcode;
                        idx  <= '0;
                        busy <= 1'b1;
                        if (cnt_sat == '0) begin
                            state <= FIN;
                        end else begin
                            last_idx    <= DEPTH_LOG2'(cnt_sat - ONE_W);
                            state       <= ISSUE;
                            falu_enable <= 1'b1;
                            falu_op1    <= op1_mem[0];
                            falu_op2    <= op2_mem[0];
                            sel_q       <= op_onehot(opcode);
                        end
                    end
                end
                ISSUE: begin
                    if (idx == last_idx) begin
                        state       <= DRAIN;
                        falu_enable <= 1'b0;
                        sel_q       <= '0;
                        falu_op1    <= '0;
                        falu_op2    <= '0;
                    end else begin
                        idx      <= idx_nx;
                        falu_op1 <= op1_mem[idx_nx];
                        falu_op2 <= op2_mem[idx_nx];
                        sel_q    <= op_onehot(op_q);
                    end
                end
                DRAIN: begin
                end
                FIN: begin
                end
                default: state <= IDLE;
            endcase
            if (fin_now) begin
                state       <= IDLE;
                busy        <= 1'b0;
                done        <= 1'b1;
                falu_enable <= 1'b0;
                sel_q       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fpu16_batch_seq.sv
// Self-checking bench for fpu16_batch_seq.
// Includes a stand-in FALU16 with configurable latency.
module tb_fpu16_batch_seq;

    localparam int DL    = 5;
    localparam int DEPTH = 32;
    localparam int LAT   = 0;
    localparam int LI    = (LAT == 0) ? 0 : LAT - 1;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          wr_en = 0;
    logic          wr_sel = 0;
    logic [DL-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          start = 0;
    logic [1:0]    opcode = '0;
    logic [DL:0]   count = '0;
    logic          busy, done, falu_enable;
    logic [15:0]   falu_op1, falu_op2, falu_result;
    logic          falu_addsel, falu_subsel, falu_mulsel, falu_divsel;
    logic [DL-1:0] rd_addr = '0;
    logic [15:0]   rd_data;

    int checks = 0;
    int fails  = 0;

    logic [15:0] op1_m [DEPTH];
    logic [15:0] op2_m [DEPTH];
    logic [15:0] res_m [DEPTH];

    always #5 clk = ~clk;

    fpu16_batch_seq #(.DEPTH_LOG2(DL), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .opcode      (opcode),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .falu_enable (falu_enable),
        .falu_op1    (falu_op1),
        .falu_op2    (falu_op2),
        .falu_addsel (falu_addsel),
        .falu_subsel (falu_subsel),
        .falu_mulsel (falu_mulsel),
        .falu_divsel (falu_divsel),
        .falu_result (falu_result),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    wire [3:0] sel_vec = {falu_divsel, falu_mulsel, falu_subsel, falu_addsel};

    // Stand-in ALU: a few exact FP16 results, arbitrary mixing otherwise
    function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s);
        logic [15:0] r;
        case (s)
            4'b0001: r = (a == 16'h3C00 && b == 16'h4000) ? 16'h4200 : a + b;
            4'b0010: r = (a == 16'h4000 && b == 16'h3C00) ? 16'h3C00 : a - b;
            4'b0100: r = (a == 16'h4200 && b == 16'h4000) ? 16'h4600
                                                          : {a[7:0], b[7:0]} ^ 16'h5A5A;
            4'b1000: r = a ^ {b[3:0], b[15:4]};
            default: r = 16'hDEAD;
        endcase
        return r;
    endfunction

    logic [15:0] alu_now;
    logic [15:0] alu_dly [4];
    always_comb alu_now = alu(falu_op1, falu_op2, sel_vec);
    always @(posedge clk) begin
        alu_dly[0] <= alu_now;
        for (int i = 1; i < 4; i++) alu_dly[i] <= alu_dly[i-1];
    end
    assign falu_result = (LAT == 0) ? alu_now : alu_dly[LI];

    task automatic write_op(input logic s, input int a, input logic [15:0] d);
        wr_en = 1; wr_sel = s; wr_addr = DL'(a); wr_data = d;
        @(negedge clk);
        wr_en = 0;
        if (s) op2_m[a] = d;
        else   op1_m[a] = d;
    endtask

    task automatic read_one(input int a, input logic [15:0] exp, input string tag);
        rd_addr = DL'(a);
        @(negedge clk);
        checks++;
        if (rd_data !== exp) begin
            fails++;
            $display("FAIL %s read[%0d] got %h want %h", tag, a, rd_data, exp);
        end
    endtask

    task automatic read_all(input string tag);
        rd_addr = '0;
        @(negedge clk);
        for (int a = 0; a < DEPTH; a++) begin
            checks++;
            if (rd_data !== res_m[a]) begin
                fails++;
                $display("FAIL %s stream[%0d] got %h want %h", tag, a, rd_data, res_m[a]);
            end
            rd_addr = DL'(a + 1);
            @(negedge clk);
        end
    endtask

    task automatic do_batch(input logic [1:0] op, input int cnt, input bit disturb,
                            input string tag);
        int nsat, done_k;
        bit een;
        logic [3:0] esel;
        nsat   = (cnt > DEPTH) ? DEPTH : cnt;
        done_k = (nsat == 0) ? 2 : nsat + LAT + 1;
        start = 1; opcode = op; count = (DL+1)'(cnt);
        @(negedge clk);
        start = 0;
        for (int k = 1; k <= done_k + 1; k++) begin
            if (disturb && k == 2) begin
                start = 1; opcode = op ^ 2'b11; count = (DL+1)'(3);
                wr_en = 1; wr_sel = 0; wr_addr = DL'(3); wr_data = ~op1_m[3];
            end
            if (disturb && k == 3) begin
                start = 0; wr_en = 0;
            end
            een  = (k <= nsat);
            esel = een ? (4'b0001 << op) : 4'b0000;
            checks++;
            if ({falu_enable, sel_vec} !== {een, esel}) begin
                fails++;
                $display("FAIL %s issue k=%0d got en=%b sel=%b want en=%b sel=%b",
                         tag, k, falu_enable, sel_vec, een, esel);
            end
            if (een) begin
                checks++;
                if ({falu_op1, falu_op2} !== {op1_m[k-1], op2_m[k-1]}) begin
                    fails++;
                    $display("FAIL %s operands k=%0d got %h/%h want %h/%h", tag, k,
                             falu_op1, falu_op2, op1_m[k-1], op2_m[k-1]);
                end
            end
            checks++;
            if ({busy, done} !== {1'(k < done_k), 1'(k == done_k)}) begin
                fails++;
                $display("FAIL %s status k=%0d got busy=%b done=%b want busy=%b done=%b",
                         tag, k, busy, done, k < done_k, k == done_k);
            end
            if (k <= done_k) @(negedge clk);
        end
        for (int i = 0; i < nsat; i++)
            res_m[i] = alu(op1_m[i], op2_m[i], 4'b0001 << op);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, falu_enable, sel_vec, falu_op1, falu_op2, rd_data} !== '0) begin
            fails++;
            $display("FAIL reset got busy=%b done=%b en=%b sel=%b op=%h/%h rd=%h want 0",
                     busy, done, falu_enable, sel_vec, falu_op1, falu_op2, rd_data);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        write_op(0, 0, 16'h3C00);
        write_op(1, 0, 16'h4000);
        do_batch(2'b00, 1, 0, "add1");
        read_one(0, 16'h4200, "add1");
    endtask

    task automatic test_mul_full();
        for (int i = 0; i < DEPTH; i++) begin
            write_op(0, i, 16'($urandom));
            write_op(1, i, 16'($urandom));
        end
        write_op(0, 7, 16'h4200);
        write_op(1, 7, 16'h4000);
        do_batch(2'b10, 32, 0, "mul32");
        read_all("mul32");
        read_one(7, 16'h4600, "mul32_fp");
    endtask

    task automatic test_count_zero();
        do_batch(2'($urandom), 0, 0, "cnt0");
        read_all("cnt0");
    endtask

    task automatic test_sub_ignore();
        write_op(0, 0, 16'h4000);
        write_op(1, 0, 16'h3C00);
        for (int i = 1; i < 4; i++) write_op(0, i, 16'($urandom));
        do_batch(2'b01, 4, 1, "sub4");
        read_one(0, 16'h3C00, "sub4");
        read_all("sub4");
    endtask

    task automatic test_saturate();
        do_batch(2'b11, 40, 0, "sat40");
        read_all("sat40");
    endtask

    task automatic test_reset_mid();
        logic [1:0] op;
        op = 2'($urandom);
        for (int i = 0; i < 20; i++) write_op(0, i, 16'($urandom));
        start = 1; opcode = op; count = (DL+1)'(20);
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (falu_enable !== 1'b1 || falu_op1 !== op1_m[10]) begin
            fails++;
            $display("FAIL rstmid index10 got en=%b op1=%h want en=1 op1=%h",
                     falu_enable, falu_op1, op1_m[10]);
        end
        rst_n = 0;
        @(negedge clk);
        checks++;
        if ({busy, done, falu_enable, sel_vec} !== 7'b0) begin
            fails++;
            $display("FAIL rstmid got busy=%b done=%b en=%b sel=%b want 0",
                     busy, done, falu_enable, sel_vec);
        end
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_quiet k=%0d got done=%b busy=%b want 0", k, done, busy);
            end
        end
        do_batch(op, 20, 0, "restart20");
        read_all("restart20");
    endtask

    task automatic test_read_stream();
        int a;
        int prev;
        read_one(5, res_m[5], "rd5");
        prev = $urandom_range(DEPTH - 1);
        rd_addr = DL'(prev);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(DEPTH - 1);
            checks++;
            if (rd_data !== res_m[prev]) begin
                fails++;
                $display("FAIL rdstream[%0d] got %h want %h", prev, rd_data, res_m[prev]);
            end
            rd_addr = DL'(a);
            prev = a;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_mul_full();
        test_count_zero();
        test_sub_ignore();
        test_saturate();
        test_reset_mid();
        test_read_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fpu16_batch_seq.md
Name: fpu16_batch_seq

Overview:
Hardware batch issuer and result collector for the FALU16 half-precision ALU.
- Holds up to 2^DEPTH_LOG2 operand pairs in two register files.
- On start, issues pairs to FALU16 with a one-hot add/sub/mul/div select and captures each result into a result buffer.
- The host reads results back through the buffer.
- Sits between the host/command bus and FALU16. It is the on-chip initiator for FALU16, replacing host-driven operand stepping.

Parameters:
DEPTH_LOG2, 5, log2 of operand/result buffer depth (32 entries)
LAT, 0, FALU16 result latency in cycles from operand/select presentation to valid falu_result (0..3)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  operand write strobe
wr_sel  in  1  0 = op1 buffer, 1 = op2 buffer
wr_addr  in  DEPTH_LOG2  operand write index
wr_data  in  16  operand value (FP16)
start  in  1  begin batch (single-cycle pulse, sampled in IDLE only)
opcode  in  2  00 add, 01 sub, 10 mul, 11 div; latched on start
count  in  DEPTH_LOG2+1  pairs to process, 0..2^DEPTH_LOG2; latched on start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse when batch complete
falu_enable  out  1  high while issuing
falu_op1  out  16  operand A to FALU16
falu_op2  out  16  operand B to FALU16
falu_addsel  out  1  one-hot select
falu_subsel  out  1  one-hot select
falu_mulsel  out  1  one-hot select
falu_divsel  out  1  one-hot select
falu_result  in  16  FALU16 opout
rd_addr  in  DEPTH_LOG2  result read index
rd_data  out  16  result at rd_addr, registered, 1-cycle read latency

Behaviour:
- Reset values:
  - FSM = IDLE; busy, done, falu_enable, all selects = 0.
  - falu_op1/op2 = 0; rd_data = 0; issue index = 0.
  - Buffer contents are not cleared.
- FSM states:
  - IDLE: start=1 latches opcode/count, index=0 -> ISSUE. If count=0, go -> FIN instead.
  - ISSUE: each cycle drives falu_op1/op2 from buffers[index] and the one-hot select for the latched opcode; falu_enable=1; index++. After index = count-1 is presented -> DRAIN.
  - DRAIN: waits until all in-flight results are captured, then -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- Issue rate: 1 pair/cycle. The index is 0..count-1, with no wrap. count > 2^DEPTH_LOG2 is saturated to 2^DEPTH_LOG2.
- Capture:
  - A LAT-deep shift register carries {valid, index}.
  - At the output stage, falu_result is written to result[index].
  - With LAT=0, the capture happens in the same cycle as the issue.
- Selects are exactly one-hot while falu_enable=1 and all-zero otherwise. Operand/select outputs are registered from FSM state.
- busy=1 in ISSUE, DRAIN and FIN. done asserts one cycle after the last capture (for LAT=0, the cycle after the last issue).
- Total batch length from start to done, for count = N > 0: N + LAT + 1 cycles. For N = 0: done 2 cycles after start.
- start while busy is ignored. Operand writes while busy are dropped, to keep the operands stable.
- rd_addr reads are allowed any time. Reading an entry written in the same cycle returns the old value.
- Reset asserted mid-batch: immediate return to IDLE, outputs go to their reset values, the partial result buffer is left as-is, and no done pulse is generated.

Decomposition:
- Shared package fpu16_pkg holds:
  - opcode constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11);
  - FSM state encoding (IDLE, ISSUE, DRAIN, FIN);
  - an opcode-to-one-hot function.
- One natural sub-module: fpu16_capture_pipe, the parameterised LAT-stage {valid, index} delay line.

Test Plan:
1. Load op1[0]=0x3C00, op2[0]=0x4000; start opcode=00 count=1, LAT=0 -> addsel one-hot for 1 cycle, result[0]=0x4200, done 2 cycles after start.
2. Load 32 pairs; start opcode=10 count=32 -> 32 consecutive issue cycles, indices 0..31 in order. Entry with 0x4200*0x4000 reads back 0x4600; done at cycle 33 (LAT=0) or 35 (LAT=2).
3. start with count=0 -> no falu_enable, busy 1 cycle, done pulse, result buffer unchanged.
4. opcode=01 with 0x4000-0x3C00 -> subsel only, result 0x3C00. A second start pulse during ISSUE is ignored, and a wr_en during ISSUE leaves the operand unchanged.
5. Drop rst_n at issue index 10 of a 20-pair batch -> next cycle busy=0, selects=0, no done. A restart then completes normally with entries 0..19 overwritten.
6. Read result[5] via rd_addr=5 -> rd_data valid the following cycle. Back-to-back reads of different addresses stream at 1 per cycle.
